// File: rtl/decode38_pkg.sv
// Shared widths, the select-code type and the one-hot helper for the
// switch-to-LED decoder.
package decode38_pkg;

    localparam int SEL_W = 3;
    localparam int LED_W = 8;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [LED_W-1:0] sel_to_onehot(input sel_t sel);
        return {{(LED_W-1){1'b0}}, 1'b1} << sel;
    endfunction

endpackage

// File: rtl/decode_38_sw_debounce.sv
// Switch synchroniser plus debounce: a new code is accepted only after it has
// been seen unchanged for STABLE_CYCLES consecutive synchronised samples.
module sw_debounce
    import decode38_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  sel_t i_sw,
    output sel_t o_stable
);

    logic [SYNC_STAGES-1:0][SEL_W-1:0] r_sync;
    sel_t                              r_prev;
    sel_t                              r_stable;
    logic [7:0]                        r_cnt;
    sel_t                              w_sync;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign o_stable = r_stable;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
        end
    end

    // r_prev lets a bounce during the count restart it from 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_prev <= w_sync;
            if (STABLE_CYCLES == 0) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_sync != r_prev) begin
                r_cnt <= 8'd1;
            end else if (r_cnt == 8'(STABLE_CYCLES)) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/decode_38.sv
// Registered 3-to-8 one-hot decoder driving board LEDs from debounced switches,
// with optional active-low LED drive.
module decode_38
    import decode38_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       SW,
    output logic [LED_W-1:0] LED
);

    sel_t             w_sel;
    sel_t             w_stable;
    logic             w_unused_sw3;
    logic [LED_W-1:0] r_led;

    // SW[3] is reserved and deliberately reaches no register.
    assign w_sel        = SW[SEL_W-1:0];
    assign w_unused_sw3 = SW[3];

    sw_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_sw_debounce (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_sw    (w_sel),
        .o_stable(w_stable)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_led <= '0;
        end else begin
            r_led <= sel_to_onehot(w_stable);
        end
    end

    assign LED = LED_ACTIVE_LOW ? ~r_led : r_led;

endmodule

// File: tb/tb_decode_38.sv
// Directed-vector bench for decode_38: reset, sweep, glitch, bounce,
// reset mid-debounce and the active-low / no-debounce parameter set.
module tb_decode_38;

    logic       clk = 1'b0;
    logic       rst_n, rst_n2;
    logic [3:0] sw, sw2;
    logic [7:0] led, led2;
    int         checks   = 0;
    int         failures = 0;

    always #10 clk = ~clk;

    decode_38 u_dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .SW   (sw),
        .LED  (led)
    );

    decode_38 #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (0),
        .LED_ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .CLK  (clk),
        .RST_N(rst_n2),
        .SW   (sw2),
        .LED  (led2)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prev_exp;
        logic [7:0] new_exp;

        // Reset held for 3 edges with a non-zero code on the switches
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        sw     = 4'b0101;
        sw2    = 4'b0000;
        repeat (3) begin
            tick();
            check_eq("rst_led", led, 8'h00);
            check_eq("rst_led_al", led2, 8'hFF);
        end
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        tick();
        check_eq("rel_first", led, 8'h01);
        check_eq("rel_first_al", led2, 8'hFE);
        repeat (10) tick();
        check_eq("settle_sel5", led, 8'h20);
        $display("reset: led=%h led_al=%h", led, led2);

        // Sweep 0..7 with SW[3] floating, 10 cycles per code
        prev_exp = 8'h20;
        for (int i = 0; i < 8; i++) begin
            new_exp = 8'h01 << i;
            sw = {1'bx, 3'(i)};
            for (int k = 1; k <= 10; k++) begin
                tick();
                check_eq("onehot", 8'($countones(led)), 8'd1);
                if (k < 8) check_eq("sweep_hold", led, prev_exp);
                else       check_eq("sweep_new", led, new_exp);
            end
            $display("sweep: sel=%0d led=%h exp=%h", i, led, new_exp);
            prev_exp = new_exp;
        end

        // Glitch: 3-cycle pulse on SW[2] with code 011 settled
        sw = 4'b0011;
        repeat (10) tick();
        check_eq("glitch_pre", led, 8'h08);
        sw = 4'b0111;
        repeat (3) begin
            tick();
            check_eq("glitch_pulse", led, 8'h08);
        end
        sw = 4'b0011;
        repeat (12) begin
            tick();
            check_eq("glitch_after", led, 8'h08);
        end
        $display("glitch: led=%h exp=08", led);

        // Bounce: 000 -> 110, then SW[0] toggles 3 times at 2-cycle spacing
        sw = 4'b0000;
        repeat (10) tick();
        check_eq("bounce_pre", led, 8'h01);
        sw = 4'b0110; repeat (2) begin tick(); check_eq("bounce_mid", led, 8'h01); end
        sw = 4'b0111; repeat (2) begin tick(); check_eq("bounce_mid", led, 8'h01); end
        sw = 4'b0110; repeat (2) begin tick(); check_eq("bounce_mid", led, 8'h01); end
        sw = 4'b0111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) check_eq("bounce_hold", led, 8'h01);
            else       check_eq("bounce_new", led, 8'h80);
        end
        $display("bounce: led=%h exp=80", led);
        repeat (2) tick();

        // Reset one edge, 4 edges after a change to 110
        sw = 4'b0110;
        repeat (3) begin
            tick();
            check_eq("mid_pre", led, 8'h80);
        end
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst", led, 8'h00);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) check_eq("mid_hold", led, 8'h01);
            else       check_eq("mid_new", led, 8'h40);
        end
        $display("reset_mid: led=%h exp=40", led);

        // Active-low, no debounce: reset reads FF, code 5 reads DF after 4 edges
        rst_n2 = 1'b0;
        tick();
        check_eq("al_rst", led2, 8'hFF);
        rst_n2 = 1'b1;
        tick();
        check_eq("al_rel", led2, 8'hFE);
        sw2 = 4'b0101;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) check_eq("al_hold", led2, 8'hFE);
            else       check_eq("al_new", led2, 8'hDF);
        end
        $display("active_low: led=%h exp=DF", led2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
